// File: rtl/axi4stream_sink_pkg.sv
// axi4stream_sink_pkg
// Shared types and helpers for the AXI4-Stream capture sink.
//   ready_mode_e : TREADY backpressure policy selector
//   LFSR_MASK    : Galois feedback taps for the 16-bit random-ready LFSR
//   popcount     : number of set bits in a byte-qualifier vector (up to 64 lanes)
package axi4stream_sink_pkg;

  typedef enum logic [1:0] {
    READY_ALWAYS = 2'd0,
    READY_NEVER  = 2'd1,
    READY_RANDOM = 2'd2,
    READY_FIFO   = 2'd3
  } ready_mode_e;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Callers zero-extend narrower keep vectors to 64 bits.
  function automatic logic [31:0] popcount(input logic [63:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + {31'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/axi4stream_sink_fifo.sv
// axi4stream_sink_fifo
// Synchronous first-word-fall-through FIFO with occupancy output.
//   clk, srst        : clock and synchronous active-high reset
//   wr_en, wr_data   : push (caller guarantees not full)
//   rd_en            : pop request, honoured only while rd_valid
//   rd_valid, rd_data: head entry, visible the cycle after it is written
//   level, full      : registered occupancy and its full flag
module axi4stream_sink_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full
);
  import axi4stream_sink_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             pop;

  assign pop      = rd_en & (level_reg != '0);
  assign rd_valid = (level_reg != '0);
  assign rd_data  = mem[rd_ptr_reg];
  assign level    = level_reg;
  assign full     = (level_reg == (AW+1)'(DEPTH));

  // Storage carries no reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/axi4stream_sink_capture.sv
// axi4stream_sink_capture
// Parametrised AXI4-Stream slave that captures accepted beats into a FIFO,
// counts beats/packets/bytes and flags stall-stability violations.
//   aclk, areset          : clock, synchronous active-high reset
//   s_t*                  : AXI4-Stream slave interface
//   ready_mode            : 0 always, 1 never, 2 LFSR-random, 3 FIFO-driven
//   ready_thresh          : random mode is ready when lfsr[7:0] < ready_thresh
//   rd_*                  : FWFT readout of captured beats
//   clr                   : synchronous clear of counters and sticky error
//   beat/pkt/byte_cnt     : wrapping 32-bit statistics
//   err_stable            : sticky stall-stability violation flag
//   fifo_level            : current FIFO occupancy
module axi4stream_sink_capture #(
  parameter int          DATA_WIDTH = 8,
  parameter bit          HAS_TLAST  = 1'b1,
  parameter bit          HAS_TKEEP  = 1'b0,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic [DATA_WIDTH-1:0]         s_tdata,
  input  logic [DATA_WIDTH/8-1:0]       s_tkeep,
  input  logic                          s_tlast,
  input  logic [1:0]                    ready_mode,
  input  logic [7:0]                    ready_thresh,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [DATA_WIDTH/8-1:0]       rd_keep,
  output logic                          rd_last,
  input  logic                          clr,
  output logic [31:0]                   beat_cnt,
  output logic [31:0]                   pkt_cnt,
  output logic [31:0]                   byte_cnt,
  output logic                          err_stable,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  import axi4stream_sink_pkg::*;

  localparam int KW = DATA_WIDTH / 8;
  localparam int FW = DATA_WIDTH + KW + 1;

  logic [15:0]           lfsr_reg;
  logic [15:0]           lfsr_next;
  logic                  gate_reg;
  logic                  gate_next;
  logic [31:0]           beat_reg;
  logic [31:0]           pkt_reg;
  logic [31:0]           byte_reg;
  logic                  err_reg;
  logic                  prev_valid_reg;
  logic                  prev_ready_reg;
  logic [DATA_WIDTH-1:0] prev_data_reg;
  logic [KW-1:0]         prev_keep_reg;
  logic                  prev_last_reg;
  logic [KW-1:0]         keep_eff;
  logic                  last_eff;
  logic                  accept;
  logic                  full;
  logic                  stall_viol;
  logic [FW-1:0]         head;
  ready_mode_e           mode;

  // Disabled sideband inputs are intentionally left unconnected internally.
  logic unused_sideband;
  assign unused_sideband = ^{s_tkeep, s_tlast};

  // Effective qualifiers: disabled fields become constants, so the stall
  // comparison below automatically ignores them.
  if (HAS_TKEEP) begin : g_keep
    assign keep_eff = s_tkeep;
  end else begin : g_nokeep
    assign keep_eff = '1;
  end

  if (HAS_TLAST) begin : g_last
    assign last_eff = s_tlast;
  end else begin : g_nolast
    assign last_eff = 1'b1;
  end

  assign mode     = ready_mode_e'(ready_mode);
  assign s_tready = gate_reg & ~full;
  assign accept   = s_tvalid & s_tready;

  assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_MASK : 16'h0000);

  always_comb begin
    gate_next = 1'b0;
    case (mode)
      READY_ALWAYS: gate_next = 1'b1;
      READY_NEVER:  gate_next = 1'b0;
      READY_RANDOM: gate_next = (lfsr_reg[7:0] < ready_thresh);
      READY_FIFO:   gate_next = 1'b1;
      default:      gate_next = 1'b0;
    endcase
  end

  // A beat offered but refused last cycle must be re-offered unchanged.
  assign stall_viol = prev_valid_reg & ~prev_ready_reg &
                      (~s_tvalid | (s_tdata != prev_data_reg) |
                       (keep_eff != prev_keep_reg) | (last_eff != prev_last_reg));

  always_ff @(posedge aclk) begin
    if (areset) begin
      lfsr_reg       <= LFSR_SEED;
      gate_reg       <= 1'b0;
      beat_reg       <= '0;
      pkt_reg        <= '0;
      byte_reg       <= '0;
      err_reg        <= 1'b0;
      prev_valid_reg <= 1'b0;
      prev_ready_reg <= 1'b0;
      prev_data_reg  <= '0;
      prev_keep_reg  <= '0;
      prev_last_reg  <= 1'b0;
    end else begin
      lfsr_reg       <= lfsr_next;
      gate_reg       <= gate_next;
      prev_valid_reg <= s_tvalid;
      prev_ready_reg <= s_tready;
      prev_data_reg  <= s_tdata;
      prev_keep_reg  <= keep_eff;
      prev_last_reg  <= last_eff;
      // clr dominates both a same-edge beat and a same-edge violation.
      if (clr) begin
        beat_reg <= '0;
        pkt_reg  <= '0;
        byte_reg <= '0;
        err_reg  <= 1'b0;
      end else begin
        if (accept) begin
          beat_reg <= beat_reg + 32'd1;
          if (last_eff) pkt_reg <= pkt_reg + 32'd1;
          byte_reg <= byte_reg + popcount(64'(keep_eff));
        end
        if (stall_viol) err_reg <= 1'b1;
      end
    end
  end

  axi4stream_sink_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (aclk),
    .srst     (areset),
    .wr_en    (accept),
    .wr_data  ({last_eff, keep_eff, s_tdata}),
    .rd_en    (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (head),
    .level    (fifo_level),
    .full     (full)
  );

  assign rd_data    = head[DATA_WIDTH-1:0];
  assign rd_keep    = head[DATA_WIDTH +: KW];
  assign rd_last    = head[FW-1];
  assign beat_cnt   = beat_reg;
  assign pkt_cnt    = pkt_reg;
  assign byte_cnt   = byte_reg;
  assign err_stable = err_reg;

endmodule

// File: tb/tb_axi4stream_sink_capture.sv
// tb_axi4stream_sink_capture
// Directed bench for the AXI4-Stream capture sink. Two instances:
//   u0: 64-bit, TKEEP+TLAST, depth 4 (backpressure, random, stall, keep, reset)
//   u1: 32-bit, TLAST only, depth 16 (basic always-ready capture)
module tb_axi4stream_sink_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset;

  logic        s_tvalid0, s_tready0, s_tlast0, rd_valid0, rd_ready0, rd_last0, clr0, err0;
  logic [63:0] s_tdata0, rd_data0;
  logic [7:0]  s_tkeep0, rd_keep0, thresh0;
  logic [1:0]  mode0;
  logic [31:0] beat0, pkt0, byte0;
  logic [2:0]  level0;

  logic        s_tvalid1, s_tready1, s_tlast1, rd_valid1, rd_ready1, rd_last1, clr1, err1;
  logic [31:0] s_tdata1, rd_data1;
  logic [3:0]  s_tkeep1, rd_keep1;
  logic [7:0]  thresh1;
  logic [1:0]  mode1;
  logic [31:0] beat1, pkt1, byte1;
  logic [4:0]  level1;

  axi4stream_sink_capture #(
    .DATA_WIDTH(64), .HAS_TLAST(1'b1), .HAS_TKEEP(1'b1), .FIFO_DEPTH(4), .LFSR_SEED(16'hACE1)
  ) u0 (
    .aclk(clk), .areset(areset), .s_tvalid(s_tvalid0), .s_tready(s_tready0),
    .s_tdata(s_tdata0), .s_tkeep(s_tkeep0), .s_tlast(s_tlast0),
    .ready_mode(mode0), .ready_thresh(thresh0),
    .rd_valid(rd_valid0), .rd_ready(rd_ready0), .rd_data(rd_data0), .rd_keep(rd_keep0),
    .rd_last(rd_last0), .clr(clr0), .beat_cnt(beat0), .pkt_cnt(pkt0), .byte_cnt(byte0),
    .err_stable(err0), .fifo_level(level0)
  );

  axi4stream_sink_capture #(
    .DATA_WIDTH(32), .HAS_TLAST(1'b1), .HAS_TKEEP(1'b0), .FIFO_DEPTH(16), .LFSR_SEED(16'hACE1)
  ) u1 (
    .aclk(clk), .areset(areset), .s_tvalid(s_tvalid1), .s_tready(s_tready1),
    .s_tdata(s_tdata1), .s_tkeep(s_tkeep1), .s_tlast(s_tlast1),
    .ready_mode(mode1), .ready_thresh(thresh1),
    .rd_valid(rd_valid1), .rd_ready(rd_ready1), .rd_data(rd_data1), .rd_keep(rd_keep1),
    .rd_last(rd_last1), .clr(clr1), .beat_cnt(beat1), .pkt_cnt(pkt1), .byte_cnt(byte1),
    .err_stable(err1), .fifo_level(level1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Popped-entry capture, sampled mid-cycle; a pop happens at the next rising edge.
  logic [63:0] pop0_q[$];
  logic [7:0]  popk0_q[$];
  logic [31:0] pop1_q[$];
  logic [3:0]  popk1_q[$];
  logic        popl1_q[$];

  always @(negedge clk) begin
    if (!areset) begin
      if (rd_valid0 && rd_ready0) begin
        pop0_q.push_back(rd_data0);
        popk0_q.push_back(rd_keep0);
      end
      if (rd_valid1 && rd_ready1) begin
        pop1_q.push_back(rd_data1);
        popk1_q.push_back(rd_keep1);
        popl1_q.push_back(rd_last1);
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one beat on u0 and hold it until it is taken.
  task automatic send0(input logic [63:0] d, input logic [7:0] k, input logic l);
    int t;
    s_tvalid0 = 1'b1;
    s_tdata0  = d;
    s_tkeep0  = k;
    s_tlast0  = l;
    t = 0;
    while (!s_tready0 && t < 50) begin
      step(1);
      t++;
    end
    if (t >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL send0_timeout: tready stayed 0 for %0d cycles, required 1", t);
    end
    step(1);
  endtask

  task automatic test_reset;
    n_cmp++; if (s_tready0 !== 1'b0) begin n_bad++; $display("FAIL rst_tready0: got %0b want 0", s_tready0); end
    n_cmp++; if (rd_valid0 !== 1'b0) begin n_bad++; $display("FAIL rst_rd_valid0: got %0b want 0", rd_valid0); end
    n_cmp++; if (beat0 !== 32'd0 || pkt0 !== 32'd0 || byte0 !== 32'd0) begin n_bad++; $display("FAIL rst_cnt0: got %0d/%0d/%0d want 0/0/0", beat0, pkt0, byte0); end
    n_cmp++; if (err0 !== 1'b0) begin n_bad++; $display("FAIL rst_err0: got %0b want 0", err0); end
    n_cmp++; if (level0 !== 3'd0) begin n_bad++; $display("FAIL rst_level0: got %0d want 0", level0); end
    n_cmp++; if (s_tready1 !== 1'b0 || level1 !== 5'd0) begin n_bad++; $display("FAIL rst_u1: got tready %0b level %0d want 0 0", s_tready1, level1); end
    areset = 1'b0;
    step(1);
    n_cmp++; if (s_tready0 !== 1'b1) begin n_bad++; $display("FAIL rst_release_tready0: got %0b want 1", s_tready0); end
  endtask

  task automatic test_basic;
    int t;
    rd_ready1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_tvalid1 = 1'b1;
      s_tdata1  = 32'(8'h11 * (i + 1));
      s_tlast1  = (i == 4);
      t = 0;
      while (!s_tready1 && t < 50) begin step(1); t++; end
      if (t >= 50) begin n_cmp++; n_bad++; $display("FAIL basic_timeout: tready1 stuck 0, required 1"); end
      step(1);
    end
    s_tvalid1 = 1'b0;
    s_tlast1  = 1'b0;
    step(4);
    n_cmp++; if (beat1 !== 32'd5) begin n_bad++; $display("FAIL basic_beat: got %0d want 5", beat1); end
    n_cmp++; if (pkt1 !== 32'd1) begin n_bad++; $display("FAIL basic_pkt: got %0d want 1", pkt1); end
    n_cmp++; if (byte1 !== 32'd20) begin n_bad++; $display("FAIL basic_byte: got %0d want 20", byte1); end
    n_cmp++; if (pop1_q.size() !== 5) begin n_bad++; $display("FAIL basic_popcount: got %0d want 5", pop1_q.size()); end
    for (int i = 0; i < 5 && i < pop1_q.size(); i++) begin
      n_cmp++;
      if (pop1_q[i] !== 32'(8'h11 * (i + 1)) || popk1_q[i] !== 4'hF || popl1_q[i] !== (i == 4)) begin
        n_bad++;
        $display("FAIL basic_order[%0d]: got %0h keep %0h last %0b want %0h keep f last %0b",
                 i, pop1_q[i], popk1_q[i], popl1_q[i], 32'(8'h11 * (i + 1)), (i == 4));
      end
    end
  endtask

  task automatic test_backpressure;
    int idx;
    logic acc;
    pop0_q.delete(); popk0_q.delete();
    rd_ready0 = 1'b0;
    mode0     = 2'd0;
    s_tkeep0  = 8'hFF;
    s_tlast0  = 1'b0;
    idx       = 1;
    s_tdata0  = 64'd1;
    s_tvalid0 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      acc = s_tvalid0 & s_tready0;
      step(1);
      if (acc) begin idx++; s_tdata0 = 64'(idx); end
    end
    n_cmp++; if (idx - 1 !== 4 || beat0 !== 32'd4) begin n_bad++; $display("FAIL bp_accepted: got %0d/%0d want 4", idx - 1, beat0); end
    n_cmp++; if (s_tready0 !== 1'b0) begin n_bad++; $display("FAIL bp_tready_full: got %0b want 0", s_tready0); end
    n_cmp++; if (level0 !== 3'd4) begin n_bad++; $display("FAIL bp_level_full: got %0d want 4", level0); end
    n_cmp++; if (rd_valid0 !== 1'b1 || rd_data0 !== 64'd1) begin n_bad++; $display("FAIL bp_head: got v%0b %0h want v1 1", rd_valid0, rd_data0); end
    rd_ready0 = 1'b1;
    step(1);
    rd_ready0 = 1'b0;
    n_cmp++; if (s_tready0 !== 1'b1 || level0 !== 3'd3) begin n_bad++; $display("FAIL bp_after_pop: got tready %0b level %0d want 1 3", s_tready0, level0); end
    step(1);
    s_tvalid0 = 1'b0;
    n_cmp++; if (beat0 !== 32'd5 || level0 !== 3'd4 || s_tready0 !== 1'b0) begin n_bad++; $display("FAIL bp_fifth: got beat %0d level %0d tready %0b want 5 4 0", beat0, level0, s_tready0); end
    rd_ready0 = 1'b1;
    step(6);
    n_cmp++; if (pop0_q.size() !== 5) begin n_bad++; $display("FAIL bp_drain_count: got %0d want 5", pop0_q.size()); end
    for (int i = 0; i < 5 && i < pop0_q.size(); i++) begin
      n_cmp++; if (pop0_q[i] !== 64'(i + 1)) begin n_bad++; $display("FAIL bp_order[%0d]: got %0h want %0h", i, pop0_q[i], i + 1); end
    end
    n_cmp++; if (err0 !== 1'b0 || level0 !== 3'd0) begin n_bad++; $display("FAIL bp_end: got err %0b level %0d want 0 0", err0, level0); end
  endtask

  task automatic test_random;
    int idx, hi, t, bad_order;
    logic acc;
    clr0 = 1'b1; step(1); clr0 = 1'b0;
    pop0_q.delete(); popk0_q.delete();
    rd_ready0 = 1'b1;
    mode0     = 2'd2;
    thresh0   = 8'd128;
    s_tkeep0  = 8'hFF;
    s_tlast0  = 1'b0;
    idx = 0; hi = 0;
    s_tdata0  = 64'd0;
    s_tvalid0 = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      if (s_tready0) hi++;
      acc = s_tvalid0 & s_tready0;
      step(1);
      if (acc) begin idx++; s_tdata0 = 64'(idx); end
    end
    // Retire the outstanding beat before dropping valid so no stall error is raised.
    t = 0;
    while (!s_tready0 && t < 1000) begin step(1); t++; end
    if (t >= 1000) begin n_cmp++; n_bad++; $display("FAIL rand_finish_timeout: tready stuck 0, required 1"); end
    step(1);
    idx++;
    s_tvalid0 = 1'b0;
    step(4);
    n_cmp++; if (hi < 4500 || hi > 5500) begin n_bad++; $display("FAIL rand_duty: got %0d ready cycles of 10000, required 4500..5500", hi); end
    n_cmp++; if (beat0 !== 32'(idx)) begin n_bad++; $display("FAIL rand_beat: got %0d want %0d", beat0, idx); end
    n_cmp++; if (pop0_q.size() !== idx) begin n_bad++; $display("FAIL rand_popcount: got %0d want %0d", pop0_q.size(), idx); end
    bad_order = 0;
    for (int i = 0; i < pop0_q.size(); i++) if (pop0_q[i] !== 64'(i)) bad_order++;
    n_cmp++; if (bad_order !== 0) begin n_bad++; $display("FAIL rand_order: got %0d out-of-order entries want 0", bad_order); end
    n_cmp++; if (err0 !== 1'b0) begin n_bad++; $display("FAIL rand_err: got %0b want 0", err0); end
  endtask

  task automatic test_random_zero;
    int hi;
    thresh0 = 8'd0;
    mode0   = 2'd2;
    step(1);
    clr0 = 1'b1; step(1); clr0 = 1'b0;
    s_tvalid0 = 1'b1;
    s_tdata0  = 64'hDEAD;
    hi = 0;
    for (int c = 0; c < 200; c++) begin
      if (s_tready0) hi++;
      step(1);
    end
    s_tvalid0 = 1'b0;
    n_cmp++; if (hi !== 0 || beat0 !== 32'd0) begin n_bad++; $display("FAIL rand0_accept: got ready %0d beats %0d want 0 0", hi, beat0); end
    step(1);
  endtask

  task automatic test_stall;
    mode0 = 2'd1;
    clr0  = 1'b1; step(1); clr0 = 1'b0;
    step(1);
    n_cmp++; if (err0 !== 1'b0 || s_tready0 !== 1'b0) begin n_bad++; $display("FAIL stall_start: got err %0b tready %0b want 0 0", err0, s_tready0); end
    s_tvalid0 = 1'b1; s_tdata0 = 64'hA5; s_tkeep0 = 8'hFF; s_tlast0 = 1'b0;
    step(2);
    n_cmp++; if (err0 !== 1'b0) begin n_bad++; $display("FAIL stall_stable: got %0b want 0", err0); end
    s_tdata0 = 64'h5A;
    step(1);
    n_cmp++; if (err0 !== 1'b1) begin n_bad++; $display("FAIL stall_data_change: got %0b want 1", err0); end
    clr0 = 1'b1; step(1); clr0 = 1'b0;
    n_cmp++; if (err0 !== 1'b0) begin n_bad++; $display("FAIL stall_clr: got %0b want 0", err0); end
    step(1);
    n_cmp++; if (err0 !== 1'b0) begin n_bad++; $display("FAIL stall_hold: got %0b want 0", err0); end
    s_tvalid0 = 1'b0;
    step(1);
    n_cmp++; if (err0 !== 1'b1) begin n_bad++; $display("FAIL stall_valid_drop: got %0b want 1", err0); end
    clr0 = 1'b1; step(1); clr0 = 1'b0;
    n_cmp++; if (err0 !== 1'b0 || beat0 !== 32'd0) begin n_bad++; $display("FAIL stall_end: got err %0b beats %0d want 0 0", err0, beat0); end
  endtask

  task automatic test_keep;
    mode0 = 2'd0;
    rd_ready0 = 1'b1;
    step(1);
    clr0 = 1'b1; step(1); clr0 = 1'b0;
    pop0_q.delete(); popk0_q.delete();
    send0(64'h0102030405060708, 8'h0F, 1'b0);
    send0(64'h1112131415161718, 8'hFF, 1'b1);
    s_tvalid0 = 1'b0; s_tlast0 = 1'b0;
    step(4);
    n_cmp++; if (byte0 !== 32'd12) begin n_bad++; $display("FAIL keep_bytes: got %0d want 12", byte0); end
    n_cmp++; if (beat0 !== 32'd2 || pkt0 !== 32'd1) begin n_bad++; $display("FAIL keep_cnt: got %0d/%0d want 2/1", beat0, pkt0); end
    n_cmp++; if (popk0_q.size() !== 2 || popk0_q[0] !== 8'h0F || popk0_q[1] !== 8'hFF) begin n_bad++; $display("FAIL keep_stored: got n%0d want 2 entries 0f ff", popk0_q.size()); end
  endtask

  task automatic test_reset_mid;
    rd_ready0 = 1'b0;
    mode0 = 2'd0;
    for (int i = 0; i < 3; i++) send0(64'(16'hBE00 + i), 8'hFF, 1'b0);
    s_tvalid0 = 1'b0;
    step(1);
    n_cmp++; if (level0 !== 3'd3) begin n_bad++; $display("FAIL mid_level: got %0d want 3", level0); end
    areset = 1'b1;
    step(1);
    n_cmp++; if (s_tready0 !== 1'b0 || rd_valid0 !== 1'b0 || level0 !== 3'd0) begin n_bad++; $display("FAIL mid_rst_flags: got tready %0b rdv %0b level %0d want 0 0 0", s_tready0, rd_valid0, level0); end
    n_cmp++; if (beat0 !== 32'd0 || pkt0 !== 32'd0 || byte0 !== 32'd0 || err0 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_cnt: got %0d/%0d/%0d err %0b want 0", beat0, pkt0, byte0, err0); end
    areset = 1'b0;
    step(1);
    pop0_q.delete(); popk0_q.delete();
    rd_ready0 = 1'b1;
    send0(64'hC0, 8'hFF, 1'b0);
    send0(64'hC1, 8'hFF, 1'b1);
    s_tvalid0 = 1'b0; s_tlast0 = 1'b0;
    step(4);
    n_cmp++; if (beat0 !== 32'd2 || pkt0 !== 32'd1 || byte0 !== 32'd16) begin n_bad++; $display("FAIL mid_next_pkt: got %0d/%0d/%0d want 2/1/16", beat0, pkt0, byte0); end
    n_cmp++; if (pop0_q.size() !== 2 || pop0_q[0] !== 64'hC0) begin n_bad++; $display("FAIL mid_next_data: got n%0d want 2 starting c0", pop0_q.size()); end
  endtask

  initial begin
    areset = 1'b1;
    s_tvalid0 = 1'b0; s_tdata0 = '0; s_tkeep0 = '0; s_tlast0 = 1'b0;
    mode0 = 2'd0; thresh0 = 8'd0; rd_ready0 = 1'b0; clr0 = 1'b0;
    s_tvalid1 = 1'b0; s_tdata1 = '0; s_tkeep1 = 4'h0; s_tlast1 = 1'b0;
    mode1 = 2'd0; thresh1 = 8'd0; rd_ready1 = 1'b0; clr1 = 1'b0;
    step(3);
    test_reset;
    test_basic;
    test_backpressure;
    test_random;
    test_random_zero;
    test_stall;
    test_keep;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
